rx_deinterleaver: RTL and testbench
===================================

// Module: rx_deinterleaver
// PURPOSE
//  Receive-side 802.11a block deinterleaver: the inverse of the Tx interleaver's two-step permutation.
//  Sits between the Rx demapper (upstream) and the Viterbi depuncturer/decoder (downstream).
//  Buffers one OFDM symbol of hard coded bits, N_CBPS = 48*N_BPSC, arriving one subcarrier per beat.
//  Then emits them one bit per beat in original (pre-interleave) order.
// PARAMETERS
//  N_SC     48   data subcarriers per OFDM symbol
//  MAX_BPSC 6    max coded bits per subcarrier; sets in_bits width and buffer size (48*6 = 288)
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   synchronous, active-high reset
//  mod       in   2   modulation: 0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM (N_BPSC = 1, 2, 4, 6)
//  in_valid  in   1   in_bits holds one subcarrier's bits
//  in_ready  out  1   block accepts a subcarrier; beat transfers when in_valid & in_ready
//  in_bits   in   6   in_bits[b] = coded bit b of the subcarrier; bits >= N_BPSC ignored
//  out_valid out  1   out_bit is valid
//  out_ready in   1   downstream accepts; beat transfers when out_valid & out_ready
//  out_bit   out  1   deinterleaved coded bit k
//  out_last  out  1   high with the final bit of the symbol (k = N_CBPS-1)
// BEHAVIOUR
//  Reset: state=FILL, sc_cnt=0, k=0; in_ready=1, out_valid=0, out_bit=0, out_last=0.
//   Buffer contents are don't-care.
//  FILL state:
//   - in_ready=1 and out_valid=0.
//   - mod is sampled into mod_q on the first accepted beat (sc_cnt=0).
//     mod is ignored for the rest of the symbol.
//   - An accepted beat writes buf[sc_cnt*N_BPSC + b] = in_bits[b] for b < N_BPSC.
//     N_BPSC is taken from mod_q, or from mod itself on the first beat.
//   - sc_cnt then increments.
//   - On the beat with sc_cnt=47: sc_cnt wraps to 0, k clears to 0, and state goes to DRAIN.
//     in_ready falls on the next cycle.
//  DRAIN state:
//   - in_ready=0 and out_valid=1.
//   - First out_valid is the cycle after the 48th subcarrier is accepted (1-cycle latency).
//   - out_bit = buf[j(k)], taken directly from the registered k counter and buffer.
//   - out_ready low holds k, out_bit and out_last stable.
//   - An accepted beat increments k.
//   - out_last = (k == N_CBPS-1).
//   - The out_last beat returns the block to FILL: in_ready=1 and out_valid=0 on the next cycle.
//   - No overlap: input is stalled for the whole drain (N_CBPS accepted beats).
//  Address map (k = original index; j = received index):
//   - c = k mod 16 and r = k / 16. Keep these as counters (c fastest, wrapping at 16), not dividers.
//   - i = (N_CBPS/16)*c + r, where N_CBPS/16 = 3, 6, 12, 18.
//   - s = max(N_BPSC/2, 1), giving s = 1, 1, 2, 3.
//   - j = s*floor(i/s) + ((i - c) mod s).
//   - s=1: j = i.
//   - s=2: j = {i[8:1], i[0]^c[0]}.
//   - s=3: use a mod-3 residue tracked alongside i. No generic divider.
//   - All address arithmetic is 9-bit unsigned. j < N_CBPS always.
//  Boundaries:
//   - rst in any state aborts the symbol: the partial buffer is discarded and the block returns to FILL.
//   - mod changes mid-FILL or mid-DRAIN have no effect until the next symbol.
//   - in_valid during DRAIN is ignored and nothing is written.
//   - out_ready while in FILL is ignored.
//   - Bubbles (in_valid=0) during FILL simply pause sc_cnt.
// TESTING
//  1. BPSK: only subcarrier 3 has in_bits[0]=1 (j=3), all other bits 0.
//     -> 48 output bits, only k=1 high; out_last on k=47.
//  2. 16-QAM: only subcarrier 3 has in_bits[1]=1 (j=13).
//     -> 192 output bits, only k=1 high; out_last on k=191.
//  3. 64-QAM: only subcarrier 3 has in_bits[0]=1 (j=18).
//     -> 288 output bits, only k=17 high.
//  4. All 4 mods, random data through the Tx interleaver model then this block.
//     -> output equals the original bits; random in_valid and out_ready stalls do not change the data.
//  5. out_ready held low for 10 cycles mid-drain at k=5.
//     -> k, out_bit and out_last stable; in_ready stays 0.
//     -> after the out_last beat, in_ready=1 on the next cycle.
//  6. rst asserted after 20 subcarriers, then mod changed before the next symbol.
//     -> outputs return to reset values; the next full symbol decodes correctly with the new mod.

Source files
------------

// File: rtl/rx_deinterleaver.sv
// rx_deinterleaver: 802.11a receive block deinterleaver.
// Buffers one OFDM symbol of coded bits, then drains them one per beat in pre-interleave order.
module rx_deinterleaver #(
   parameter int N_SC     = 48,
   parameter int MAX_BPSC = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mod,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MAX_BPSC-1:0] in_bits,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_bit,
   output logic                out_last
);
   typedef enum logic {FILL, DRAIN} state_t;
   localparam int DEPTH = N_SC * MAX_BPSC;
   state_t state;
   logic [DEPTH-1:0] mem;
   logic [1:0] mod_q, mod_w, rm3, cm3, d3;
   logic [5:0] sc_cnt;
   logic [3:0] c;
   logic [4:0] r;
   logic [8:0] k, i, j, ncbps, n16, base;
   logic [2:0] nb_w, nb_q;
   logic fill_go, drain_go;

   function automatic logic [2:0] bpsc(input logic [1:0] m);
      return m == 2'd0 ? 3'd1 : m == 2'd1 ? 3'd2 : m == 2'd2 ? 3'd4 : 3'd6;
   endfunction

   // i = (N_CBPS/16)*c + r is tracked incrementally; for 64-QAM i mod 3 equals r mod 3
   always_comb begin
      fill_go   = state == FILL && in_valid;
      drain_go  = state == DRAIN && out_ready;
      mod_w     = sc_cnt == 6'd0 ? mod : mod_q;
      nb_w      = bpsc(mod_w);
      nb_q      = bpsc(mod_q);
      base      = 9'(sc_cnt) * 9'(nb_w);
      ncbps     = 9'd48 * 9'(nb_q);
      n16       = 9'd3 * 9'(nb_q);
      d3        = rm3 >= cm3 ? rm3 - cm3 : rm3 + 2'd3 - cm3;
      j         = mod_q[1] ? (mod_q[0] ? i - 9'(rm3) + 9'(d3) : {i[8:1], i[0] ^ c[0]}) : i;
      in_ready  = state == FILL;
      out_valid = state == DRAIN;
      out_last  = out_valid && k == ncbps - 9'd1;
      out_bit   = out_valid && mem[j];
   end

   always_ff @(posedge clk)
      if (fill_go)
         for (int b = 0; b < MAX_BPSC; b++)
            if (3'(b) < nb_w)
               mem[base + 9'(b)] <= in_bits[b];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FILL;
         mod_q  <= 2'd0;
         sc_cnt <= 6'd0;
         k      <= 9'd0;
         c      <= 4'd0;
         r      <= 5'd0;
         i      <= 9'd0;
         rm3    <= 2'd0;
         cm3    <= 2'd0;
      end else if (fill_go) begin
         mod_q <= mod_w;
         if (sc_cnt == 6'(N_SC - 1)) begin
            state  <= DRAIN;
            sc_cnt <= 6'd0;
            k      <= 9'd0;
            c      <= 4'd0;
            r      <= 5'd0;
            i      <= 9'd0;
            rm3    <= 2'd0;
            cm3    <= 2'd0;
         end else begin
            sc_cnt <= sc_cnt + 6'd1;
         end
      end else if (drain_go) begin
         k   <= k + 9'd1;
         cm3 <= c == 4'd15 || cm3 == 2'd2 ? 2'd0 : cm3 + 2'd1;
         if (c == 4'd15) begin
            c   <= 4'd0;
            r   <= r + 5'd1;
            i   <= 9'(r) + 9'd1;
            rm3 <= rm3 == 2'd2 ? 2'd0 : rm3 + 2'd1;
         end else begin
            c <= c + 4'd1;
            i <= i + n16;
         end
         if (out_last)
            state <= FILL;
      end
   end
endmodule

// File: tb/tb_rx_deinterleaver.sv
// tb_rx_deinterleaver: drives symbols through a Tx interleaver model into the block and
// scoreboards the deinterleaved bit stream, plus literal single-bit placement cases.
module tb_rx_deinterleaver;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, out_bit, out_last;
   logic [1:0] mod;
   logic [5:0] in_bits;
   int checks = 0, errors = 0;
   logic [1:0] exp_q[$];
   logic [1:0] e;
   int ones_q[$];
   int kcnt = 0, sym_len = 0;
   int stall_in = 0, stall_out = 0;
   bit manual = 1'b0;
   bit orig[288];
   bit rx[288];

   always #5 clk = ~clk;

   rx_deinterleaver dut (
      .clk(clk), .rst(rst), .mod(mod), .in_valid(in_valid), .in_ready(in_ready),
      .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
      .out_bit(out_bit), .out_last(out_last)
   );

   function automatic int nb_of(input int m);
      return m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 4 : 6;
   endfunction

   // Forward Tx interleaver: original index k -> transmitted index j
   function automatic int tx_j(input int k, input int m);
      int n = 48 * nb_of(m);
      int s = nb_of(m) / 2 > 1 ? nb_of(m) / 2 : 1;
      int i = (n / 16) * (k % 16) + k / 16;
      return s * (i / s) + (i + n - (16 * i) / n) % s;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic make_rx(input int m);
      for (int k = 0; k < 48 * nb_of(m); k++) rx[tx_j(k, m)] = orig[k];
   endtask

   task automatic make_orig(input int m);
      for (int k = 0; k < 48 * nb_of(m); k++) orig[k] = rx[tx_j(k, m)];
   endtask

   task automatic send_sym(input int m, input int n_sc);
      int nb = nb_of(m);
      int t;
      for (int sc = 0; sc < n_sc; sc++) begin
         while ($urandom_range(0, 99) < stall_in) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         mod = sc == 0 ? 2'(m) : 2'($urandom);
         for (int b = 0; b < 6; b++) in_bits[b] = b < nb ? rx[sc * nb + b] : 1'($urandom);
         t = 0;
         while (!in_ready && t < 3000) begin
            @(posedge clk); #1;
            t++;
         end
         if (!in_ready) chk("in_ready_timeout", 0, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (n_sc == 48) begin
         chk("first_out_valid", out_valid, 1);
         chk("in_ready_drain", in_ready, 0);
         for (int k = 0; k < 48 * nb; k++) exp_q.push_back({k == 48 * nb - 1, orig[k]});
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_remaining", exp_q.size(), 0);
   endtask

   task automatic directed(input int m, input int jpos, input int want_k);
      ones_q.delete();
      for (int x = 0; x < 288; x++) rx[x] = 1'b0;
      rx[jpos] = 1'b1;
      make_orig(m);
      send_sym(m, 48);
      wait_drain();
      chk("ones_count", ones_q.size(), 1);
      if (ones_q.size() > 0) chk("one_position", ones_q[0], want_k);
      chk("symbol_length", sym_len, 48 * nb_of(m));
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!manual) out_ready = $urandom_range(0, 99) >= stall_out;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         kcnt = 0;
      end else begin
         checks++;
         if (in_ready !== !out_valid) begin
            errors++;
            $display("FAIL handshake in_ready=%0b out_valid=%0b want complementary", in_ready, out_valid);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat got bit=%0b last=%0b want no beat", out_bit, out_last);
            end else begin
               e = exp_q.pop_front();
               if ({out_last, out_bit} !== e) begin
                  errors++;
                  $display("FAIL out_beat k=%0d got last=%0b bit=%0b want last=%0b bit=%0b",
                           kcnt, out_last, out_bit, e[1], e[0]);
               end
            end
            if (out_bit) ones_q.push_back(kcnt);
            if (out_last) begin
               sym_len = kcnt + 1;
               kcnt = 0;
            end else begin
               kcnt++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_bits = 6'd0;
      mod = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_out_last", out_last, 0);
      rst = 1'b0;
      // single marked bit per modulation
      directed(0, 3, 1);
      directed(2, 13, 1);
      directed(3, 18, 17);
      // random data through the interleaver model with stalls on both sides
      stall_in = 30;
      stall_out = 30;
      for (int rep = 0; rep < 2; rep++)
         for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 288; k++) orig[k] = 1'($urandom);
            make_rx(m);
            send_sym(m, 48);
         end
      wait_drain();
      // downstream stall at k=5
      stall_in = 0;
      manual = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 288; k++) orig[k] = 1'($urandom);
      make_rx(1);
      send_sym(1, 48);
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      chk("stall_remaining", exp_q.size(), 96 - 5);
      repeat (10) begin
         @(posedge clk); #1;
         chk("stall_out_bit", out_bit, int'(exp_q[0][0]));
         chk("stall_out_last", out_last, int'(exp_q[0][1]));
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      for (int t = 0; t < 200 && !(out_valid && out_last); t++) begin
         @(posedge clk); #1;
      end
      chk("last_seen", out_valid && out_last, 1);
      @(posedge clk); #1;
      chk("after_last_in_ready", in_ready, 1);
      chk("after_last_out_valid", out_valid, 0);
      manual = 1'b0;
      stall_out = 20;
      // abort mid-fill, then a new symbol with a different modulation
      for (int k = 0; k < 288; k++) orig[k] = 1'($urandom);
      make_rx(3);
      send_sym(3, 20);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_bit", out_bit, 0);
      chk("abort_out_last", out_last, 0);
      rst = 1'b0;
      stall_in = 20;
      for (int k = 0; k < 288; k++) orig[k] = 1'($urandom);
      make_rx(1);
      send_sym(1, 48);
      wait_drain();
      chk("post_abort_length", sym_len, 96);
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
